fpmul_scheduler: RTL and testbench
==================================

FPMUL_SCHEDULER -- requirements
Module: fpmul_scheduler

Interface
REQ-001 Parameter LAT, default 2, multiplier latency in cycles (legal 1..8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 enable  input  1  1 = grant new operations; 0 = stop granting and drain.
REQ-005 reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-006 reqN_ready  output  1  requester N is granted this cycle.
REQ-007 reqN_x, reqN_y  input  32 each  IEEE-754 single operands.
REQ-008 reqN_mode  input  3  rounding mode for the operation.
REQ-009 mul_fp_X, mul_fp_Y  output  32 each  operands to the shared multiplier.
REQ-010 mul_r_mode  output  3  rounding mode to the multiplier.
REQ-011 mul_fp_Z  input  32  multiplier product.
REQ-012 mul_ovrf, mul_udrf  input  1 each  multiplier overflow / underflow flags.
REQ-013 rspN_valid  output  1  one-cycle pulse, result for requester N.
REQ-014 rspN_z  output  32  product returned to requester N.
REQ-015 rspN_ovrf, rspN_udrf  output  1 each  flags returned to requester N.
REQ-016 busy  output  1  at least one operation in flight.
REQ-017 idle  output  1  FSM in IDLE.

Function
REQ-018 FSM states IDLE, RUN, DRAIN; IDLE->RUN when enable=1; RUN->DRAIN when enable=0; DRAIN->IDLE when no operation in flight; DRAIN->RUN when enable=1.
REQ-019 Grants only in RUN, at most one per cycle; reqN_ready is combinational from reqN_valid, state, and the round-robin pointer.
REQ-020 Only one valid: grant it. Both valid: grant the requester not granted most recently; pointer updates only on a handshake (valid&ready).
REQ-021 On handshake at edge E: mul_fp_X/mul_fp_Y/mul_r_mode register the granted operands at E; otherwise they hold their last value.
REQ-022 Multiplier result for the operation issued at E is sampled at edge E+LAT; a LAT-deep tag pipeline (valid bit + requester id) tracks ownership.
REQ-023 At edge E+LAT the sampled z/ovrf/udrf register onto the owning rspN_*; rspN_valid is high exactly one cycle; the other requester's rsp_valid stays 0.
REQ-024 Throughput one operation per cycle; back-to-back grants are never stalled by in-flight operations; responses have no backpressure.
REQ-025 rspN_z/ovrf/udrf hold their last value when rspN_valid=0.
REQ-026 busy = OR of tag pipeline valid bits; idle = (state==IDLE).
REQ-027 enable falling in a cycle: no grant that cycle; in-flight operations still complete and respond.
REQ-028 Response ordering per requester equals grant order.

Reset
REQ-029 rst asserted: state=IDLE, tag pipeline cleared, round-robin pointer favours requester 0, all outputs 0, immediately (asynchronous).
REQ-030 Reset mid-operation discards in-flight operations; no rspN_valid pulse follows deassertion for them.
REQ-031 Outputs defined from deassertion; first grant no earlier than the edge after IDLE->RUN.

Structure
REQ-032 Package fpmul_sched_pkg holds the state enum, default LAT, FP width (32), mode width (3), and the tag struct (valid, id).
REQ-033 Sub-module fpmul_rr_arb implements the 2-way round-robin grant and pointer; the rest stays in fpmul_scheduler.

Verification
REQ-034 LAT=2, enable=1, req0 x=0x40400000 y=0x40000000 mode=0 -> handshake at E, rsp0_valid one cycle after E+2, rsp0_z=0x40C00000, flags 0, rsp1_valid never 1.
REQ-035 Both requesters valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; 6 responses in the same order, one per cycle.
REQ-036 req1 x=0x7F000000 y=0x7F000000 -> rsp1_ovrf=1; x=0x00800000 y=0x00800000 -> rsp1_udrf=1.
REQ-037 Issue 2 operations, drop enable next cycle -> no further ready, state DRAIN, both responses delivered, busy 1->0, idle=1 the cycle after.
REQ-038 Assert rst one cycle after a grant -> all outputs 0 at once, no rsp_valid after release, next grant goes to requester 0 when both valid.

Source files
------------

// File: rtl/fpmul_sched_pkg.sv
// rtl/fpmul_sched_pkg.sv - shared types and constants for the fp multiplier scheduler
package fpmul_sched_pkg;
    localparam int DEFAULT_LAT = 2;
    localparam int FP_W        = 32;
    localparam int MODE_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;
endpackage

// File: rtl/fpmul_scheduler_if.sv
// rtl/fpmul_scheduler_if.sv - requester, multiplier and response signals of the scheduler
interface fpmul_scheduler_if;
    import fpmul_sched_pkg::*;

    logic              req0_valid, req0_ready;
    logic [FP_W-1:0]   req0_x, req0_y;
    logic [MODE_W-1:0] req0_mode;
    logic              req1_valid, req1_ready;
    logic [FP_W-1:0]   req1_x, req1_y;
    logic [MODE_W-1:0] req1_mode;

    logic [FP_W-1:0]   mul_fp_X, mul_fp_Y, mul_fp_Z;
    logic [MODE_W-1:0] mul_r_mode;
    logic              mul_ovrf, mul_udrf;

    logic              rsp0_valid, rsp0_ovrf, rsp0_udrf;
    logic [FP_W-1:0]   rsp0_z;
    logic              rsp1_valid, rsp1_ovrf, rsp1_udrf;
    logic [FP_W-1:0]   rsp1_z;

    logic              busy, idle;

    modport master (
        output req0_valid, req0_x, req0_y, req0_mode,
        output req1_valid, req1_x, req1_y, req1_mode,
        input  req0_ready, req1_ready,
        input  mul_fp_X, mul_fp_Y, mul_r_mode,
        output mul_fp_Z, mul_ovrf, mul_udrf,
        input  rsp0_valid, rsp0_z, rsp0_ovrf, rsp0_udrf,
        input  rsp1_valid, rsp1_z, rsp1_ovrf, rsp1_udrf,
        input  busy, idle
    );

    modport slave (
        input  req0_valid, req0_x, req0_y, req0_mode,
        input  req1_valid, req1_x, req1_y, req1_mode,
        output req0_ready, req1_ready,
        output mul_fp_X, mul_fp_Y, mul_r_mode,
        input  mul_fp_Z, mul_ovrf, mul_udrf,
        output rsp0_valid, rsp0_z, rsp0_ovrf, rsp0_udrf,
        output rsp1_valid, rsp1_z, rsp1_ovrf, rsp1_udrf,
        output busy, idle
    );
endinterface

// File: rtl/fpmul_rr_arb.sv
// rtl/fpmul_rr_arb.sv - two-way round-robin grant with a last-winner pointer
module fpmul_rr_arb (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic valid0,
    input  logic valid1,
    output logic ready0,
    output logic ready1
);
    // pref=1 means requester 1 wins a tie; it flips only on a handshake
    logic pref;

    assign ready0 = en & valid0 & (~valid1 | ~pref);
    assign ready1 = en & valid1 & (~valid0 | pref);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pref <= 1'b0;
        end else if (ready0) begin
            pref <= 1'b1;
        end else if (ready1) begin
            pref <= 1'b0;
        end
    end
endmodule

// File: rtl/fpmul_scheduler.sv
// rtl/fpmul_scheduler.sv - shares one pipelined fp multiplier between two requesters
module fpmul_scheduler
    import fpmul_sched_pkg::*;
#(
    parameter int LAT = DEFAULT_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    fpmul_scheduler_if.slave  bus
);
    state_t state, next_state;
    logic   grant_en, idle_st;
    logic   hs, sel, busy_any;
    tag_t   tags [LAT];
    tag_t   out_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (enable) next_state = ST_RUN;
            ST_RUN:   if (!enable) next_state = ST_DRAIN;
            ST_DRAIN: begin
                if (enable)         next_state = ST_RUN;
                else if (!busy_any) next_state = ST_IDLE;
            end
            default:  next_state = ST_IDLE;
        endcase
    end

    // Gating on enable as well as RUN blocks a grant in the cycle enable falls
    always_comb begin
        grant_en = 1'b0;
        idle_st  = 1'b0;
        grant_en = (state == ST_RUN) && enable;
        idle_st  = (state == ST_IDLE);
    end

    fpmul_rr_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (grant_en),
        .valid0 (bus.req0_valid),
        .valid1 (bus.req1_valid),
        .ready0 (bus.req0_ready),
        .ready1 (bus.req1_ready)
    );

    assign hs  = bus.req0_ready | bus.req1_ready;
    assign sel = bus.req1_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mul_fp_X   <= '0;
            bus.mul_fp_Y   <= '0;
            bus.mul_r_mode <= '0;
        end else if (hs) begin
            bus.mul_fp_X   <= sel ? bus.req1_x    : bus.req0_x;
            bus.mul_fp_Y   <= sel ? bus.req1_y    : bus.req0_y;
            bus.mul_r_mode <= sel ? bus.req1_mode : bus.req0_mode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) tags[i] <= '0;
        end else begin
            tags[0] <= '{valid: hs, id: sel};
            for (int i = 1; i < LAT; i++) tags[i] <= tags[i-1];
        end
    end

    always_comb begin
        busy_any = 1'b0;
        for (int i = 0; i < LAT; i++) busy_any = busy_any | tags[i].valid;
    end

    // The last tag stage names the owner of the product present on mul_fp_Z now
    assign out_tag = tags[LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp0_valid <= 1'b0;
            bus.rsp0_z     <= '0;
            bus.rsp0_ovrf  <= 1'b0;
            bus.rsp0_udrf  <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            bus.rsp1_z     <= '0;
            bus.rsp1_ovrf  <= 1'b0;
            bus.rsp1_udrf  <= 1'b0;
        end else begin
            bus.rsp0_valid <= out_tag.valid & ~out_tag.id;
            bus.rsp1_valid <= out_tag.valid & out_tag.id;
            if (out_tag.valid && !out_tag.id) begin
                bus.rsp0_z    <= bus.mul_fp_Z;
                bus.rsp0_ovrf <= bus.mul_ovrf;
                bus.rsp0_udrf <= bus.mul_udrf;
            end
            if (out_tag.valid && out_tag.id) begin
                bus.rsp1_z    <= bus.mul_fp_Z;
                bus.rsp1_ovrf <= bus.mul_ovrf;
                bus.rsp1_udrf <= bus.mul_udrf;
            end
        end
    end

    assign bus.busy = busy_any;
    assign bus.idle = idle_st & ~rst;
endmodule

// File: tb/tb_fpmul_scheduler.sv
// tb/tb_fpmul_scheduler.sv - randomized self-checking bench for fpmul_scheduler
module tb_fpmul_scheduler;
    import fpmul_sched_pkg::*;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    always #5 clk = ~clk;

    fpmul_scheduler_if bus ();

    fpmul_scheduler #(.LAT(LAT)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stand-in multiplier: truncating product, mode folded into the LSBs; returns {ovf,udf,z}
    function automatic logic [33:0] fmul(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
        logic [23:0] ma, mb;
        logic [47:0] p;
        logic [22:0] mant;
        logic        s;
        int          e;
        s  = a[31] ^ b[31];
        ma = {1'b1, a[22:0]};
        mb = {1'b1, b[22:0]};
        p  = 48'(ma) * 48'(mb);
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            mant = p[46:24];
            e++;
        end else begin
            mant = p[45:23];
        end
        if (e >= 255) return {2'b10, s, 8'hFF, 23'h0};
        if (e <= 0)   return {2'b01, s, 31'h0};
        return {2'b00, s, e[7:0], mant ^ {20'h0, m}};
    endfunction

    // Multiplier sees its operands one edge after issue, so with LAT=2 the product is ready by E+2
    logic [66:0] mdly = '0;
    logic [33:0] prod;
    always @(posedge clk) mdly <= {bus.mul_r_mode, bus.mul_fp_X, bus.mul_fp_Y};
    assign prod = fmul(mdly[63:32], mdly[31:0], mdly[66:64]);
    assign bus.mul_fp_Z = prod[31:0];
    assign bus.mul_udrf = prod[32];
    assign bus.mul_ovrf = prod[33];

    // Behavioural model: state as 0=IDLE 1=RUN 2=DRAIN, tie preference, queue of pending results
    typedef struct {
        int          due;
        bit          id;
        logic [33:0] res;
    } pend_t;

    pend_t       pq [$];
    int          ms = 0;
    bit          mpref = 1'b0;
    int          cyc = 0;
    logic [31:0] ex = '0, ey = '0;
    logic [2:0]  em = '0;
    bit          ev [2];
    logic [31:0] ez [2];
    bit          eo [2];
    bit          eu [2];

    function automatic bit exp_ready(input int n);
        bit v0, v1;
        v0 = bus.req0_valid;
        v1 = bus.req1_valid;
        if (ms != 1 || !enable) return 1'b0;
        if (n == 0) return v0 && (!v1 || mpref == 1'b0);
        return v1 && (!v0 || mpref == 1'b1);
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit    g0, g1, id;
        pend_t p;
        if (rst) begin
            pq.delete();
            ms = 0; mpref = 1'b0; cyc = 0;
            ex = '0; ey = '0; em = '0;
            for (int i = 0; i < 2; i++) begin
                ev[i] = 1'b0; ez[i] = '0; eo[i] = 1'b0; eu[i] = 1'b0;
            end
        end else begin
            g0 = exp_ready(0);
            g1 = exp_ready(1);
            cyc++;
            case (ms)
                0: if (enable) ms = 1;
                1: if (!enable) ms = 2;
                default: if (enable) ms = 1; else if (pq.size() == 0) ms = 0;
            endcase
            ev[0] = 1'b0;
            ev[1] = 1'b0;
            if (pq.size() > 0 && pq[0].due == cyc) begin
                p = pq.pop_front();
                ev[p.id] = 1'b1;
                ez[p.id] = p.res[31:0];
                eu[p.id] = p.res[32];
                eo[p.id] = p.res[33];
            end
            if (g0 || g1) begin
                id = g1;
                ex = id ? bus.req1_x : bus.req0_x;
                ey = id ? bus.req1_y : bus.req0_y;
                em = id ? bus.req1_mode : bus.req0_mode;
                p.due = cyc + LAT;
                p.id  = id;
                p.res = fmul(ex, ey, em);
                pq.push_back(p);
                mpref = !id;
            end
        end
    end

    int dglog [$];
    int drlog [$];
    int drcyc [$];
    int ncyc = 0;

    always @(negedge clk) begin
        ncyc++;
        if (chk_on) begin
            cmp("req0_ready", bus.req0_ready, exp_ready(0));
            cmp("req1_ready", bus.req1_ready, exp_ready(1));
            cmp("mul_fp_X", bus.mul_fp_X, ex);
            cmp("mul_fp_Y", bus.mul_fp_Y, ey);
            cmp("mul_r_mode", bus.mul_r_mode, em);
            cmp("rsp0_valid", bus.rsp0_valid, ev[0]);
            cmp("rsp1_valid", bus.rsp1_valid, ev[1]);
            cmp("rsp0_z", bus.rsp0_z, ez[0]);
            cmp("rsp1_z", bus.rsp1_z, ez[1]);
            cmp("rsp0_flags", {bus.rsp0_ovrf, bus.rsp0_udrf}, {eo[0], eu[0]});
            cmp("rsp1_flags", {bus.rsp1_ovrf, bus.rsp1_udrf}, {eo[1], eu[1]});
            cmp("busy", bus.busy, pq.size() != 0);
            cmp("idle", bus.idle, (ms == 0) && !rst);
            if (bus.req0_ready) dglog.push_back(0);
            if (bus.req1_ready) dglog.push_back(1);
            if (bus.rsp0_valid) begin drlog.push_back(0); drcyc.push_back(ncyc); end
            if (bus.rsp1_valid) begin drlog.push_back(1); drcyc.push_back(ncyc); end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int n, input bit v, input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_x = x; bus.req0_y = y; bus.req0_mode = m;
        end else begin
            bus.req1_valid = v; bus.req1_x = x; bus.req1_y = y; bus.req1_mode = m;
        end
    endtask

    function automatic logic [31:0] rnd_fp();
        return $urandom;
    endfunction

    initial begin : stim
        int base, rbase;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        #1 rst = 1'b1;
        #1 chk_on = 1'b1;
        step();
        cmp("rst_idle", bus.idle, 1'b0);
        cmp("rst_busy", bus.busy, 1'b0);
        cmp("rst_rsp0_z", bus.rsp0_z, 32'h0);
        step();
        rst = 1'b0;
        step();
        cmp("post_rst_idle", bus.idle, 1'b1);

        cmp("model_3x2", fmul(32'h40400000, 32'h40000000, 3'd0), {2'b00, 32'h40C00000});
        cmp("model_ovf", fmul(32'h7F000000, 32'h7F000000, 3'd0), {2'b10, 32'h7F800000});
        cmp("model_udf", fmul(32'h00800000, 32'h00800000, 3'd0), {2'b01, 32'h00000000});

        // single operation from requester 0
        enable = 1'b1;
        step();
        set_req(0, 1'b1, 32'h40400000, 32'h40000000, 3'd0);
        #1;
        cmp("single_ready0", bus.req0_ready, 1'b1);
        cmp("single_ready1", bus.req1_ready, 1'b0);
        step();
        set_req(0, 1'b0, '0, '0, '0);
        cmp("single_mul_X", bus.mul_fp_X, 32'h40400000);
        cmp("single_mul_Y", bus.mul_fp_Y, 32'h40000000);
        step();
        cmp("single_early", bus.rsp0_valid, 1'b0);
        step();
        cmp("single_valid", bus.rsp0_valid, 1'b1);
        cmp("single_z", bus.rsp0_z, 32'h40C00000);
        cmp("single_flags", {bus.rsp0_ovrf, bus.rsp0_udrf}, 2'b00);
        cmp("single_rsp1", bus.rsp1_valid, 1'b0);
        step();
        cmp("single_pulse", bus.rsp0_valid, 1'b0);
        cmp("single_hold", bus.rsp0_z, 32'h40C00000);

        // overflow then underflow on requester 1
        set_req(1, 1'b1, 32'h7F000000, 32'h7F000000, 3'd0);
        step();
        set_req(1, 1'b1, 32'h00800000, 32'h00800000, 3'd0);
        step();
        set_req(1, 1'b0, '0, '0, '0);
        step();
        cmp("ovf_valid", bus.rsp1_valid, 1'b1);
        cmp("ovf_flags", {bus.rsp1_ovrf, bus.rsp1_udrf}, 2'b10);
        step();
        cmp("udf_valid", bus.rsp1_valid, 1'b1);
        cmp("udf_flags", {bus.rsp1_ovrf, bus.rsp1_udrf}, 2'b01);
        step();

        // both requesters valid for 6 cycles
        base = dglog.size();
        rbase = drlog.size();
        for (int i = 0; i < 6; i++) begin
            set_req(0, 1'b1, rnd_fp(), rnd_fp(), 3'($urandom));
            set_req(1, 1'b1, rnd_fp(), rnd_fp(), 3'($urandom));
            step();
        end
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        repeat (LAT + 2) step();
        cmp("alt_grants", dglog.size() - base, 6);
        cmp("alt_rsps", drlog.size() - rbase, 6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < dglog.size()) cmp("alt_grant_id", dglog[base+i], i % 2);
            if (rbase + i < drlog.size()) cmp("alt_rsp_id", drlog[rbase+i], i % 2);
            if (i > 0 && rbase + i < drcyc.size())
                cmp("alt_rsp_gap", drcyc[rbase+i] - drcyc[rbase+i-1], 1);
        end

        // randomized traffic with occasional enable drops
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(0, 7) != 0);
            set_req(0, 1'($urandom), rnd_fp(), rnd_fp(), 3'($urandom));
            set_req(1, 1'($urandom), rnd_fp(), rnd_fp(), 3'($urandom));
            step();
        end
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        enable = 1'b1;
        repeat (LAT + 3) step();

        // two grants then drain
        set_req(0, 1'b1, 32'h3F800000, 32'h40000000, 3'd1);
        step();
        set_req(0, 1'b1, 32'h40400000, 32'h40400000, 3'd2);
        step();
        enable = 1'b0;
        #1;
        cmp("drain_no_ready", bus.req0_ready, 1'b0);
        step();
        cmp("drain_ready", bus.req0_ready, 1'b0);
        cmp("drain_busy1", bus.busy, 1'b1);
        cmp("drain_first_rsp", bus.rsp0_valid, 1'b1);
        step();
        cmp("drain_second_rsp", bus.rsp0_valid, 1'b1);
        cmp("drain_busy0", bus.busy, 1'b0);
        cmp("drain_not_idle", bus.idle, 1'b0);
        step();
        cmp("drain_idle", bus.idle, 1'b1);
        set_req(0, 1'b0, '0, '0, '0);

        // reset one cycle after a grant
        enable = 1'b1;
        step();
        set_req(0, 1'b1, 32'h40A00000, 32'h40A00000, 3'd0);
        step();
        set_req(0, 1'b0, '0, '0, '0);
        step();
        rst = 1'b1;
        #1;
        cmp("rst_mid_X", bus.mul_fp_X, 32'h0);
        cmp("rst_mid_busy", bus.busy, 1'b0);
        cmp("rst_mid_rsp0", {bus.rsp0_valid, bus.rsp0_z}, 33'h0);
        cmp("rst_mid_idle", bus.idle, 1'b0);
        step();
        rst = 1'b0;
        rbase = drlog.size();
        step();
        set_req(0, 1'b1, 32'h40000000, 32'h40000000, 3'd0);
        set_req(1, 1'b1, 32'h40400000, 32'h40000000, 3'd0);
        #1;
        cmp("post_rst_ready0", bus.req0_ready, 1'b1);
        cmp("post_rst_ready1", bus.req1_ready, 1'b0);
        step();
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        repeat (LAT + 3) step();
        cmp("post_rst_rsp_count", drlog.size() - rbase, 1);
        if (drlog.size() > rbase) cmp("post_rst_rsp_id", drlog[rbase], 0);

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
